// File: rtl/byte_write_coalescer_pkg.sv
// Shared types and helpers for the byte write coalescer: entry layout, FSM states
// and the byte-merge function used when a request lands on a pending word.
package byte_write_coalescer_pkg;

  localparam int DATA_W     = 32;
  localparam int BYTES      = 4;
  // Entry addresses are stored zero-extended so the entry layout is independent of memory size.
  localparam int ADDR_W_MAX = 16;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_W_MAX-1:0] addr;
    logic [BYTES-1:0]      byteEn;
    logic [DATA_W-1:0]     data;
  } entry_t;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    FLUSH   = 2'd1,
    DONE    = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [BYTES-1:0]  byteEn;
  } merged_t;

  function automatic merged_t merge_bytes(
    input logic [DATA_W-1:0] old_data,
    input logic [BYTES-1:0]  old_en,
    input logic [DATA_W-1:0] new_data,
    input logic [BYTES-1:0]  new_en
  );
    merged_t m;
    m.data   = old_data;
    m.byteEn = old_en | new_en;
    for (int i = 0; i < BYTES; i++) begin
      if (new_en[i]) m.data[8*i +: 8] = new_data[8*i +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/byte_write_coalescer_if.sv
// Byte-masked write request channel (valid/ready) into the coalescer.
interface byte_write_coalescer_if #(
  parameter int LOG_MEM_SIZE = 4
);
  import byte_write_coalescer_pkg::*;

  logic                    req_valid;
  logic                    req_ready;
  logic [LOG_MEM_SIZE-1:0] req_addr;
  logic [BYTES-1:0]        req_byteEn;
  logic [DATA_W-1:0]       req_data;

  modport master (
    output req_valid, req_addr, req_byteEn, req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_addr, req_byteEn, req_data,
    output req_ready
  );

endinterface

// File: rtl/byte_write_coalescer_match.sv
// Parallel address compare of an incoming request against all pending entries;
// the head is excluded while it is popping so a racing request allocates instead.
module coalesce_match
  import byte_write_coalescer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0]                 ent_valid,
  input  logic [DEPTH-1:0][ADDR_W_MAX-1:0] ent_addr,
  input  logic [$clog2(DEPTH)-1:0]         head,
  input  logic                             head_pop,
  input  logic [ADDR_W_MAX-1:0]            addr,
  output logic                             hit,
  output logic [DEPTH-1:0]                 onehot
);
  localparam int PW = $clog2(DEPTH);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
    assign onehot[gi] = ent_valid[gi] && (ent_addr[gi] == addr) &&
                        !(head_pop && (head == PW'(gi)));
  end

  assign hit = |onehot;

endmodule

// File: rtl/byte_write_coalescer.sv
// Coalescing write buffer in front of a byte-enable memory: merges partial writes
// per word and drains one word per cycle. Optional read overlay: BYTE_WRITE_COALESCER_READ_BYPASS_EN.
module byte_write_coalescer
  import byte_write_coalescer_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int LOG_MEM_SIZE = 4,
  parameter int TIMEOUT      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  byte_write_coalescer_if.slave    bus,
  input  logic                     flush,
  output logic                     flush_done,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     mem_writeEn,
  output logic [BYTES-1:0]         mem_byteEn,
  output logic [LOG_MEM_SIZE-1:0]  mem_writeAddr,
  output logic [DATA_W-1:0]        mem_writeData
`ifdef BYTE_WRITE_COALESCER_READ_BYPASS_EN
  ,
  input  logic [LOG_MEM_SIZE-1:0]  rd_addr,
  input  logic [DATA_W-1:0]        mem_readData,
  output logic [DATA_W-1:0]        rd_data
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [AW-1:0] TIMEOUT_C = AW'(TIMEOUT);

  entry_t        ent_reg [DEPTH];
  logic [PW-1:0] head_reg, tail_reg;
  logic [CW-1:0] count_reg, count_next;
  logic [AW-1:0] age_reg, age_next;
  state_t        state_reg, state_next;

  logic                             ready_int, accept, pop, do_merge, do_alloc, hit;
  logic [DEPTH-1:0]                 hit_onehot, ent_valid;
  logic [DEPTH-1:0][ADDR_W_MAX-1:0] ent_addr;
  logic [ADDR_W_MAX-1:0]            req_addr_ext;
  logic [DATA_W-1:0]                sel_data;
  logic [BYTES-1:0]                 sel_en;
  merged_t                          merged;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flat
    assign ent_valid[gi] = ent_reg[gi].valid;
    assign ent_addr[gi]  = ent_reg[gi].addr;
  end

  assign req_addr_ext = ADDR_W_MAX'(bus.req_addr);
  assign bus.req_ready = ready_int;
  assign count = count_reg;

  assign accept = bus.req_valid && ready_int;
  assign pop    = (count_reg != '0) &&
                  ((count_reg == DEPTH_C) || (state_reg == FLUSH) || (age_reg == TIMEOUT_C));
  // An all-zero mask is consumed here and never reaches an entry.
  assign do_merge = accept && (bus.req_byteEn != '0) && hit;
  assign do_alloc = accept && (bus.req_byteEn != '0) && !hit;

  coalesce_match #(.DEPTH(DEPTH)) u_match (
    .ent_valid (ent_valid),
    .ent_addr  (ent_addr),
    .head      (head_reg),
    .head_pop  (pop),
    .addr      (req_addr_ext),
    .hit       (hit),
    .onehot    (hit_onehot)
  );

  always_comb begin
    sel_data = '0;
    sel_en   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (hit_onehot[i]) begin
        sel_data |= ent_reg[i].data;
        sel_en   |= ent_reg[i].byteEn;
      end
    end
  end

  assign merged = merge_bytes(sel_data, sel_en, bus.req_data, bus.req_byteEn);

  always_comb begin
    count_next = count_reg + CW'(do_alloc) - CW'(pop);
    if (pop || (count_reg == '0))  age_next = '0;
    else if (age_reg != TIMEOUT_C) age_next = age_reg + AW'(1);
    else                           age_next = age_reg;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst) begin
        ent_reg[i] <= '0;
      end else if (do_alloc && (tail_reg == PW'(i))) begin
        ent_reg[i].valid  <= 1'b1;
        ent_reg[i].addr   <= req_addr_ext;
        ent_reg[i].byteEn <= bus.req_byteEn;
        ent_reg[i].data   <= bus.req_data;
      end else if (do_merge && hit_onehot[i]) begin
        ent_reg[i].byteEn <= merged.byteEn;
        ent_reg[i].data   <= merged.data;
      end else if (pop && (head_reg == PW'(i))) begin
        ent_reg[i].valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      age_reg   <= '0;
    end else begin
      head_reg  <= head_reg + PW'(pop);
      tail_reg  <= tail_reg + PW'(do_alloc);
      count_reg <= count_next;
      age_reg   <= age_next;
    end
  end

  // Popped head is registered straight onto the memory port; idle cycles drive zeros.
  always_ff @(posedge clk) begin
    if (rst || !pop) begin
      mem_writeEn   <= 1'b0;
      mem_byteEn    <= '0;
      mem_writeAddr <= '0;
      mem_writeData <= '0;
    end else begin
      mem_writeEn   <= 1'b1;
      mem_byteEn    <= ent_reg[head_reg].byteEn;
      mem_writeAddr <= ent_reg[head_reg].addr[LOG_MEM_SIZE-1:0];
      mem_writeData <= ent_reg[head_reg].data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= COLLECT;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      COLLECT: if (flush) state_next = FLUSH;
      FLUSH:   if (count_next == '0) state_next = DONE;
      DONE:    state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  always_comb begin
    ready_int  = (count_reg < DEPTH_C) && (state_reg == COLLECT);
    flush_done = (state_reg == DONE);
  end

`ifdef BYTE_WRITE_COALESCER_READ_BYPASS_EN
  logic [PW-1:0] byp_idx;

  // Lowest priority first: memory, then the in-flight write, then pending entries oldest to newest.
  always_comb begin
    rd_data = mem_readData;
    byp_idx = head_reg;
    if (mem_writeEn && (mem_writeAddr == rd_addr)) begin
      for (int b = 0; b < BYTES; b++) begin
        if (mem_byteEn[b]) rd_data[8*b +: 8] = mem_writeData[8*b +: 8];
      end
    end
    for (int k = 0; k < DEPTH; k++) begin
      byp_idx = head_reg + PW'(k);
      if (ent_reg[byp_idx].valid && (ent_reg[byp_idx].addr == ADDR_W_MAX'(rd_addr))) begin
        for (int b = 0; b < BYTES; b++) begin
          if (ent_reg[byp_idx].byteEn[b]) rd_data[8*b +: 8] = ent_reg[byp_idx].data[8*b +: 8];
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_byte_write_coalescer.sv
// Randomized and directed bench for byte_write_coalescer against a queue-based
// reference model of the buffering, merge, drain and flush rules.
module tb_byte_write_coalescer;

  localparam int DEPTH   = 4;
  localparam int LOGM    = 4;
  localparam int TIMEOUT = 8;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        flush_done;
  logic [2:0]  count;
  logic        mem_writeEn;
  logic [3:0]  mem_byteEn;
  logic [3:0]  mem_writeAddr;
  logic [31:0] mem_writeData;
`ifdef BYTE_WRITE_COALESCER_READ_BYPASS_EN
  logic [3:0]  rd_addr;
  logic [31:0] mem_readData;
  logic [31:0] rd_data;
  assign rd_addr      = 4'd0;
  assign mem_readData = 32'd0;
`endif

  byte_write_coalescer_if #(.LOG_MEM_SIZE(LOGM)) bus ();

  byte_write_coalescer #(.DEPTH(DEPTH), .LOG_MEM_SIZE(LOGM), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .flush         (flush),
    .flush_done    (flush_done),
    .count         (count),
    .mem_writeEn   (mem_writeEn),
    .mem_byteEn    (mem_byteEn),
    .mem_writeAddr (mem_writeAddr),
    .mem_writeData (mem_writeData)
`ifdef BYTE_WRITE_COALESCER_READ_BYPASS_EN
    ,
    .rd_addr       (rd_addr),
    .mem_readData  (mem_readData),
    .rd_data       (rd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  addr;
    logic [3:0]  be;
    logic [31:0] data;
  } ment_t;

  ment_t       mq[$];
  int          mst;   // 0 collecting, 1 flushing, 2 flush done
  int          mage;
  logic        e_we;
  logic [3:0]  e_be;
  logic [3:0]  e_addr;
  logic [31:0] e_data;
  int          n_checks;
  int          n_errors;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock of stimulus: the model advances on the same inputs, then every output is compared.
  task automatic cycle(input bit v, input logic [3:0] a, input logic [3:0] be,
                       input logic [31:0] d, input bit fl, input bit r);
    int    sz;
    bit    rdy;
    bit    pp;
    bit    found;
    ment_t h;
    bus.req_valid  = v;
    bus.req_addr   = a;
    bus.req_byteEn = be;
    bus.req_data   = d;
    flush          = fl;
    rst            = r;
    e_we = 1'b0; e_be = '0; e_addr = '0; e_data = '0;
    if (r) begin
      mq.delete();
      mst  = 0;
      mage = 0;
    end else begin
      sz  = mq.size();
      rdy = (sz < DEPTH) && (mst == 0);
      pp  = (sz > 0) && (sz == DEPTH || mst == 1 || mage == TIMEOUT);
      if (pp) begin
        h = mq.pop_front();
        e_we = 1'b1; e_be = h.be; e_addr = h.addr; e_data = h.data;
      end
      if (v && rdy && be != 4'd0) begin
        found = 1'b0;
        foreach (mq[k]) begin
          if (mq[k].addr == a) begin
            for (int b = 0; b < 4; b++)
              if (be[b]) mq[k].data[8*b +: 8] = d[8*b +: 8];
            mq[k].be = mq[k].be | be;
            found = 1'b1;
          end
        end
        if (!found) mq.push_back('{a, be, d});
      end
      mage = (pp || sz == 0) ? 0 : ((mage < TIMEOUT) ? mage + 1 : mage);
      case (mst)
        0: if (fl) mst = 1;
        1: if (mq.size() == 0) mst = 2;
        default: mst = 0;
      endcase
    end
    @(posedge clk);
    #1;
    check("writeEn", mem_writeEn, e_we);
    check("byteEn", mem_byteEn, e_be);
    if (e_we) begin
      check("writeAddr", mem_writeAddr, e_addr);
      check("writeData", mem_writeData, e_data);
      $display("mem write addr %0h be %b data %08h", mem_writeAddr, mem_byteEn, mem_writeData);
    end
    check("count", count, mq.size());
    check("flush_done", flush_done, mst == 2);
    check("req_ready", bus.req_ready, (mq.size() < DEPTH) && (mst == 0));
    rst   = 1'b0;
    flush = 1'b0;
    bus.req_valid = 1'b0;
  endtask

  task automatic idle();
    cycle(1'b0, 4'd0, 4'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b0, 4'd0, 4'd0, 32'd0, 1'b0, 1'b1);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    mst = 0; mage = 0;
    rst = 1'b1; flush = 1'b0;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_byteEn = '0; bus.req_data = '0;

    do_reset();
    do_reset();
    check("rst_count", count, 0);
    check("rst_ready", bus.req_ready, 1);
    check("rst_writeEn", mem_writeEn, 0);
    check("rst_flush_done", flush_done, 0);

    // Two partial writes to one word leave as a single merged write.
    cycle(1'b1, 4'd3, 4'b0001, 32'h000000AA, 1'b0, 1'b0);
    cycle(1'b1, 4'd3, 4'b0100, 32'h00BB0000, 1'b0, 1'b0);
    check("merge_count", count, 1);
    cycle(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 1'b0);
    idle();
    check("merge_we", mem_writeEn, 1);
    check("merge_be", mem_byteEn, 4'b0101);
    check("merge_data", mem_writeData, 32'h00BB00AA);
    check("merge_done", flush_done, 1);
    idle();
    check("merge_no_second", mem_writeEn, 0);

    // Zero mask is consumed without effect.
    do_reset();
    cycle(1'b1, 4'd5, 4'b0000, 32'hDEADBEEF, 1'b0, 1'b0);
    check("zero_count", count, 0);
    cycle(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 1'b0);
    check("zero_done_early", flush_done, 0);
    idle();
    check("zero_done", flush_done, 1);
    check("zero_we", mem_writeEn, 0);

    // Fill the buffer, then flush the rest in order.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 4'(i), 4'b1111, 32'h1000 + i, 1'b0, 1'b0);
    check("full_ready", bus.req_ready, 0);
    idle();
    check("full_we", mem_writeEn, 1);
    check("full_addr0", mem_writeAddr, 0);
    cycle(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) idle();

    // Timeout drains a lone entry nine edges after acceptance.
    do_reset();
    cycle(1'b1, 4'd7, 4'b1111, 32'h77777777, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      idle();
      check("tmo_quiet", mem_writeEn, 0);
    end
    idle();
    check("tmo_we", mem_writeEn, 1);
    check("tmo_count", count, 0);

    // Request to the head while the head pops on timeout allocates a fresh entry.
    do_reset();
    cycle(1'b1, 4'd0, 4'b0001, 32'h00000011, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) idle();
    cycle(1'b1, 4'd0, 4'b0010, 32'h00002200, 1'b0, 1'b0);
    check("race_old_be", mem_byteEn, 4'b0001);
    check("race_count", count, 1);
    cycle(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 1'b0);
    idle();
    check("race_new_be", mem_byteEn, 4'b0010);
    check("race_new_data", mem_writeData, 32'h00002200);

    // Reset during a flush discards what is left.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'(8 + i), 4'b0011, 32'hABCD0000 + i, 1'b0, 1'b0);
    cycle(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 1'b0);
    idle();
    check("rflush_first", mem_writeEn, 1);
    do_reset();
    check("rflush_we", mem_writeEn, 0);
    check("rflush_count", count, 0);
    for (int i = 0; i < 12; i++) idle();

    // Randomized traffic with bursty and quiet phases so merges, fills and timeouts all occur.
    for (int i = 0; i < 1500; i++) begin
      int vp;
      vp = ((i % 200) < 100) ? 60 : 8;
      cycle(($urandom % 100) < vp, 4'($urandom_range(0, 5)), 4'($urandom_range(0, 15)),
            $urandom, ($urandom % 100) < 4, ($urandom % 1000) < 4);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
